// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial unsigned adder with a three-state controller.
// The adder takes one operand bit per cycle, LSB first, and finishes in WIDTH
// RUN cycles followed by a single DONE cycle that pulses done.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the two's-complement
// overflow output ovf.

// Half adder used as a building block of the serial full adder.
module half_adder (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter must hold 0..WIDTH-1.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             w_last;
  logic             w_ha0_s;
  logic             w_ha0_c;
  logic             w_fa_s;
  logic             w_ha1_c;
  logic             w_fa_c;
`ifdef SERIAL_ADD_OVF_EN
  logic             r_ovf;
`endif

  // Full adder for the current bit: two half adders plus an OR for the carry.
  half_adder u_ha0 (
    .i_x (r_a[0]),
    .i_y (r_b[0]),
    .o_s (w_ha0_s),
    .o_c (w_ha0_c)
  );

  half_adder u_ha1 (
    .i_x (w_ha0_s),
    .i_y (r_carry),
    .o_s (w_fa_s),
    .o_c (w_ha1_c)
  );

  assign w_fa_c = w_ha0_c | w_ha1_c;

  // Current RUN cycle processes the MSB.
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Next-state decode for the controller.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_RUN;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register plus registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_DONE);
    end
  end

  // Operand capture, serial shift datapath, carry and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // Operands are captured only here, so later changes on a/b
          // cannot disturb the operation in flight.
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          r_carry <= w_fa_c;
          r_cnt   <= r_cnt + CW'(1);
`ifdef SERIAL_ADD_OVF_EN
          // On the MSB cycle r_carry is the carry into the MSB.
          if (w_last) begin
            r_ovf <= r_carry ^ w_fa_c;
          end
`endif
        end
        S_DONE: begin
          // Results hold until the next accepted start.
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_carry;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH=8): a vector table for the
// arithmetic plus hand sequences for reset abort, ignored start and held start.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  int n_checks;
  int n_fail;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int lat;
    int busy_lo;
    int pulses;
    int prev;
    logic [WIDTH-1:0] cap_sum;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h3C, 8'hC4, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h64, 8'h64, 8'hC8, 1'b0, 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum", {24'd0, sum}, 32'd0);
    check("reset_cout", {31'd0, carry_out}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Table-driven arithmetic, latency and hold checks.
    for (int i = 0; i < 8; i++) begin
      a     = vecs[i].va;
      b     = vecs[i].vb;
      start = 1'b1;
      tick();
      start = 1'b0;
      a     = ~vecs[i].va;
      b     = 8'h55;
      lat     = 31;
      busy_lo = 0;
      for (int k = 1; k <= 30; k++) begin
        tick();
        if (!busy) busy_lo++;
        if (done) begin
          lat = k;
          break;
        end
      end
      check($sformatf("v%0d_latency", i), lat, WIDTH);
      check($sformatf("v%0d_busy", i), busy_lo, 0);
      check($sformatf("v%0d_sum", i), {24'd0, sum}, {24'd0, vecs[i].exp_sum});
      check($sformatf("v%0d_cout", i), {31'd0, carry_out}, {31'd0, vecs[i].exp_cout});
`ifdef SERIAL_ADD_OVF_EN
      check($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].exp_ovf});
`endif
      tick();
      check($sformatf("v%0d_done_drop", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
      tick();
      tick();
      check($sformatf("v%0d_sum_hold", i), {24'd0, sum}, {24'd0, vecs[i].exp_sum});
      check($sformatf("v%0d_cout_hold", i), {31'd0, carry_out}, {31'd0, vecs[i].exp_cout});
    end

    // Reset three cycles into RUN aborts FF+FF with no done pulse.
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'd0);
    check("abort_cout", {31'd0, carry_out}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);

    // Reset wins over start on the same edge.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    check("rst_prio_busy", {31'd0, busy}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check("rst_prio_idle", {31'd0, busy}, 32'd0);

    // Start during RUN is ignored: 10+20 completes, one pulse only.
    a     = 8'h10;
    b     = 8'h20;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    a     = 8'h01;
    b     = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses  = 0;
    cap_sum = 8'h00;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) begin
        pulses++;
        cap_sum = sum;
      end
    end
    check("midrun_pulses", pulses, 1);
    check("midrun_sum", {24'd0, cap_sum}, 32'h30);

    // Held start re-accepts every WIDTH+2 cycles.
    a      = 8'h03;
    b      = 8'h04;
    start  = 1'b1;
    pulses = 0;
    prev   = 0;
    for (int t = 1; t <= 25; t++) begin
      tick();
      if (done) begin
        pulses++;
        check($sformatf("held_sum_p%0d", pulses), {24'd0, sum}, 32'h07);
        if (prev == 0) begin
          check("held_first_at", t, WIDTH + 1);
        end else begin
          check($sformatf("held_period_p%0d", pulses), t - prev, WIDTH + 2);
        end
        prev = t;
      end
    end
    check("held_pulses", pulses, 2);
    start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    check("held_drain_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
